// File: rtl/spi_fb_loader.sv
// spi_fb_loader: turns a stream of SPI bytes into framebuffer pixel writes,
// palette writes and a hardware fill of the whole framebuffer with one index.
// Each chip-select frame carries a command byte followed by its payload.
module spi_fb_loader #(
    parameter int unsigned FB_PIXELS = 76800,
    parameter int unsigned FB_AW     = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             frame_start,
    input  logic             frame_end,
    output logic [FB_AW-1:0] rgb_addr,
    output logic [7:0]       rgb_in,
    output logic             wren_rgb,
    output logic [7:0]       palette_addr,
    output logic [23:0]      palette_in,
    output logic             wren_palette,
    output logic             busy,
    output logic             overrun,
    output logic             bad_cmd
);

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR2, ADDR1, ADDR0, PIX,
        PAL_IDX, PAL_R, PAL_G, PAL_B,
        FILL_VAL, FILL, DISCARD
    } state_e;

    localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(FB_PIXELS - 1);
    localparam logic [FB_AW:0]   FILL_LEN  = (FB_AW + 1)'(FB_PIXELS);

    state_e             state_q, state_d;
    logic [7:0]         addr_hi_q, addr_hi_d;
    logic [7:0]         addr_mid_q, addr_mid_d;
    logic [FB_AW-1:0]   pix_addr_q, pix_addr_d;
    logic [7:0]         pal_idx_q, pal_idx_d;
    logic [7:0]         pal_r_q, pal_r_d;
    logic [7:0]         pal_g_q, pal_g_d;
    logic [7:0]         fill_val_q, fill_val_d;
    logic [FB_AW:0]     fill_cnt_q, fill_cnt_d;
    logic [FB_AW-1:0]   rgb_addr_q, rgb_addr_d;
    logic [7:0]         rgb_in_q, rgb_in_d;
    logic               wren_rgb_q, wren_rgb_d;
    logic [7:0]         palette_addr_q, palette_addr_d;
    logic [23:0]        palette_in_q, palette_in_d;
    logic               wren_palette_q, wren_palette_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic               bad_cmd_q, bad_cmd_d;

    // Start address from the three big-endian bytes, truncated and clamped into range.
    logic [FB_AW-1:0]   addr_low;
    logic [FB_AW-1:0]   addr_start;
    logic [FB_AW-1:0]   pix_addr_next;

    // Address arithmetic shared by the ADDR0 and PIX states.
    always_comb begin
        addr_low      = FB_AW'({addr_hi_q, addr_mid_q, byte_in});
        addr_start    = ({1'b0, addr_low} >= FILL_LEN) ? '0 : addr_low;
        pix_addr_next = (pix_addr_q == LAST_ADDR) ? '0 : pix_addr_q + FB_AW'(1);
    end

    // Next-state and next-output logic for the command FSM.
    always_comb begin
        // NOTE: every _d takes a hold/idle default first, so no path leaves a latch.
        state_d        = state_q;
        addr_hi_d      = addr_hi_q;
        addr_mid_d     = addr_mid_q;
        pix_addr_d     = pix_addr_q;
        pal_idx_d      = pal_idx_q;
        pal_r_d        = pal_r_q;
        pal_g_d        = pal_g_q;
        fill_val_d     = fill_val_q;
        fill_cnt_d     = fill_cnt_q;
        rgb_addr_d     = rgb_addr_q;
        rgb_in_d       = rgb_in_q;
        wren_rgb_d     = 1'b0;
        palette_addr_d = palette_addr_q;
        palette_in_d   = palette_in_q;
        wren_palette_d = 1'b0;
        busy_d         = busy_q;
        overrun_d      = overrun_q;
        bad_cmd_d      = bad_cmd_q;

        if (state_q == FILL) begin
            // The fill owns the framebuffer port; frames and bytes are ignored.
            if (byte_valid) begin
                overrun_d = 1'b1;
            end
            if (fill_cnt_q == FILL_LEN) begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                fill_cnt_d = '0;
            end else begin
                wren_rgb_d = 1'b1;
                rgb_addr_d = fill_cnt_q[FB_AW-1:0];
                rgb_in_d   = fill_val_q;
                fill_cnt_d = fill_cnt_q + (FB_AW + 1)'(1);
            end
        end else if (frame_start) begin
            // A new frame abandons whatever partial transaction was in flight.
            state_d   = CMD;
            overrun_d = 1'b0;
            bad_cmd_d = 1'b0;
        end else begin
            if (byte_valid) begin
                case (state_q)
                    CMD: begin
                        case (byte_in)
                            8'h01:   state_d = ADDR2;
                            8'h02:   state_d = PAL_IDX;
                            8'h03:   state_d = FILL_VAL;
                            default: begin
                                state_d   = DISCARD;
                                bad_cmd_d = 1'b1;
                            end
                        endcase
                    end
                    ADDR2: begin
                        addr_hi_d = byte_in;
                        state_d   = ADDR1;
                    end
                    ADDR1: begin
                        addr_mid_d = byte_in;
                        state_d    = ADDR0;
                    end
                    ADDR0: begin
                        pix_addr_d = addr_start;
                        state_d    = PIX;
                    end
                    PIX: begin
                        wren_rgb_d = 1'b1;
                        rgb_addr_d = pix_addr_q;
                        rgb_in_d   = byte_in;
                        pix_addr_d = pix_addr_next;
                    end
                    PAL_IDX: begin
                        pal_idx_d = byte_in;
                        state_d   = PAL_R;
                    end
                    PAL_R: begin
                        pal_r_d = byte_in;
                        state_d = PAL_G;
                    end
                    PAL_G: begin
                        pal_g_d = byte_in;
                        state_d = PAL_B;
                    end
                    PAL_B: begin
                        wren_palette_d = 1'b1;
                        palette_addr_d = pal_idx_q;
                        palette_in_d   = {pal_r_q, pal_g_q, byte_in};
                        pal_idx_d      = pal_idx_q + 8'd1;
                        state_d        = PAL_R;
                    end
                    FILL_VAL: begin
                        // The first fill write (address 0) goes out with the entry
                        // into FILL, so busy and wren_rgb span the same cycles.
                        fill_val_d = byte_in;
                        rgb_addr_d = '0;
                        rgb_in_d   = byte_in;
                        wren_rgb_d = 1'b1;
                        fill_cnt_d = (FB_AW + 1)'(1);
                        busy_d     = 1'b1;
                        state_d    = FILL;
                    end
                    default: ;
                endcase
            end
            // Chip-select release closes the frame after the coincident byte is
            // handled; an already committed fill still runs to completion.
            if (frame_end && state_d != FILL) begin
                state_d = IDLE;
            end
        end
    end

    // State and registered outputs; reset aborts any fill or transaction at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too, so every output reads 0 while in reset.
            state_q        <= IDLE;
            addr_hi_q      <= '0;
            addr_mid_q     <= '0;
            pix_addr_q     <= '0;
            pal_idx_q      <= '0;
            pal_r_q        <= '0;
            pal_g_q        <= '0;
            fill_val_q     <= '0;
            fill_cnt_q     <= '0;
            rgb_addr_q     <= '0;
            rgb_in_q       <= '0;
            wren_rgb_q     <= 1'b0;
            palette_addr_q <= '0;
            palette_in_q   <= '0;
            wren_palette_q <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            bad_cmd_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together on the edge.
            state_q        <= state_d;
            addr_hi_q      <= addr_hi_d;
            addr_mid_q     <= addr_mid_d;
            pix_addr_q     <= pix_addr_d;
            pal_idx_q      <= pal_idx_d;
            pal_r_q        <= pal_r_d;
            pal_g_q        <= pal_g_d;
            fill_val_q     <= fill_val_d;
            fill_cnt_q     <= fill_cnt_d;
            rgb_addr_q     <= rgb_addr_d;
            rgb_in_q       <= rgb_in_d;
            wren_rgb_q     <= wren_rgb_d;
            palette_addr_q <= palette_addr_d;
            palette_in_q   <= palette_in_d;
            wren_palette_q <= wren_palette_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
            bad_cmd_q      <= bad_cmd_d;
        end
    end

    assign rgb_addr     = rgb_addr_q;
    assign rgb_in       = rgb_in_q;
    assign wren_rgb     = wren_rgb_q;
    assign palette_addr = palette_addr_q;
    assign palette_in   = palette_in_q;
    assign wren_palette = wren_palette_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
    assign bad_cmd      = bad_cmd_q;

endmodule

// File: tb/tb_spi_fb_loader.sv
// tb_spi_fb_loader: scoreboard bench. A frame-level reference model turns each
// byte frame into the list of framebuffer/palette writes it must produce; a
// monitor pops and compares every strobe the DUT presents.
module tb_spi_fb_loader;

    localparam int unsigned FB_PIXELS = 76800;
    localparam int unsigned FB_AW     = 17;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic        pal;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             frame_start;
    logic             frame_end;
    logic [FB_AW-1:0] rgb_addr;
    logic [7:0]       rgb_in;
    logic             wren_rgb;
    logic [7:0]       palette_addr;
    logic [23:0]      palette_in;
    logic             wren_palette;
    logic             busy;
    logic             overrun;
    logic             bad_cmd;

    int  checks   = 0;
    int  failures = 0;
    wr_t exp_q[$];
    bit  ignore_writes = 1'b0;
    wr_t mon_e;

    spi_fb_loader #(.FB_PIXELS(FB_PIXELS), .FB_AW(FB_AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .rgb_addr     (rgb_addr),
        .rgb_in       (rgb_in),
        .wren_rgb     (wren_rgb),
        .palette_addr (palette_addr),
        .palette_in   (palette_in),
        .wren_palette (wren_palette),
        .busy         (busy),
        .overrun      (overrun),
        .bad_cmd      (bad_cmd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input logic pal, input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({pal, a, d});
    endtask

    // Reference model: the writes a complete frame must produce, and whether it is a bad command.
    task automatic model_frame(input byte_q_t b, output bit exp_bad);
        int unsigned a;
        int unsigned idx;
        logic [23:0] a24;
        exp_bad = 1'b0;
        if (b.size() == 0) return;
        case (b[0])
            8'h01: begin
                if (b.size() >= 4) begin
                    a24 = {b[1], b[2], b[3]};
                    a   = 32'(a24) & ((32'd1 << FB_AW) - 1);
                    if (a >= FB_PIXELS) a = 0;
                    for (int i = 4; i < b.size(); i++) begin
                        push_wr(1'b0, a, 32'(b[i]));
                        a = (a + 1) % FB_PIXELS;
                    end
                end
            end
            8'h02: begin
                if (b.size() >= 2) begin
                    idx = 32'(b[1]);
                    for (int i = 2; i + 2 < b.size(); i += 3) begin
                        push_wr(1'b1, idx, 32'({b[i], b[i+1], b[i+2]}));
                        idx = (idx + 1) % 256;
                    end
                end
            end
            8'h03: begin
                if (b.size() >= 2) begin
                    for (int i = 0; i < int'(FB_PIXELS); i++) push_wr(1'b0, i, 32'(b[1]));
                end
            end
            default: exp_bad = 1'b1;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input byte_q_t b, input bit end_with_last);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < b.size(); i++) begin
            repeat ($urandom_range(0, 2)) tick();
            byte_in    = b[i];
            byte_valid = 1'b1;
            if (end_with_last && i == b.size() - 1) frame_end = 1'b1;
            tick();
            byte_valid = 1'b0;
            frame_end  = 1'b0;
        end
        if (!end_with_last) begin
            repeat ($urandom_range(0, 2)) tick();
            frame_end = 1'b1;
            tick();
            frame_end = 1'b0;
        end
        tick();
        tick();
    endtask

    // Monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && !ignore_writes && (wren_rgb || wren_palette)) begin
            if (wren_rgb && wren_palette) begin
                check("strobes_exclusive", 32'(wren_palette), 32'd0);
            end else if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: rgb=%0b pal=%0b addr=0x%0h, expected no write",
                         wren_rgb, wren_palette, wren_rgb ? 32'(rgb_addr) : 32'(palette_addr));
            end else begin
                mon_e = exp_q.pop_front();
                check("write_kind", 32'(wren_palette), 32'(mon_e.pal));
                if (wren_rgb) begin
                    check("rgb_addr", 32'(rgb_addr), mon_e.addr);
                    check("rgb_in", 32'(rgb_in), mon_e.data);
                end else begin
                    check("palette_addr", 32'(palette_addr), mon_e.addr);
                    check("palette_in", 32'(palette_in), mon_e.data);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_wren_rgb"}, 32'(wren_rgb), 32'd0);
        check({tag, "_wren_palette"}, 32'(wren_palette), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_bad_cmd"}, 32'(bad_cmd), 32'd0);
        check({tag, "_rgb_addr"}, 32'(rgb_addr), 32'd0);
        check({tag, "_rgb_in"}, 32'(rgb_in), 32'd0);
        check({tag, "_palette_addr"}, 32'(palette_addr), 32'd0);
        check({tag, "_palette_in"}, 32'(palette_in), 32'd0);
    endtask

    initial begin
        byte_q_t     fb;
        bit          eb;
        int unsigned sel;
        int unsigned n;
        int unsigned a;
        logic [7:0]  c;
        int          fill_cycles;

        rst_n       = 1'b0;
        byte_in     = 8'h00;
        byte_valid  = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Pixel write, then wrap at the last pixel.
        fb = '{8'h01, 8'h00, 8'h01, 8'h2C, 8'hAA, 8'hBB};
        model_frame(fb, eb);
        send_frame(fb, 1'b0);
        fb = '{8'h01, 8'h01, 8'h2B, 8'hFF, 8'h11, 8'h22};
        model_frame(fb, eb);
        send_frame(fb, 1'b1);
        // Out-of-range start address clamps to 0; high bits above FB_AW are dropped.
        fb = '{8'h01, 8'h01, 8'h2C, 8'h00, 8'h33};
        model_frame(fb, eb);
        send_frame(fb, 1'b0);
        fb = '{8'h01, 8'hFF, 8'h00, 8'h05, 8'h44};
        model_frame(fb, eb);
        send_frame(fb, 1'b0);

        // Palette write with index wrap, then a partial triplet and a clean follow-up.
        fb = '{8'h02, 8'hFF, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        model_frame(fb, eb);
        send_frame(fb, 1'b0);
        fb = '{8'h02, 8'h05, 8'h10, 8'h20};
        model_frame(fb, eb);
        send_frame(fb, 1'b0);
        fb = '{8'h02, 8'h05, 8'h01, 8'h02, 8'h03};
        model_frame(fb, eb);
        send_frame(fb, 1'b0);

        // Bad command: sticky flag, no strobes, cleared by the next frame_start.
        fb = '{8'h09, 8'hAA, 8'hBB, 8'hCC};
        model_frame(fb, eb);
        send_frame(fb, 1'b0);
        check("bad_cmd_set", 32'(bad_cmd), 32'(eb));
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("bad_cmd_cleared", 32'(bad_cmd), 32'd0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;

        // Randomized frames against the model.
        for (int f = 0; f < 40; f++) begin
            fb  = {};
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                fb.push_back(8'h01);
                case ($urandom_range(0, 2))
                    0:       a = $urandom_range(FB_PIXELS - 8, FB_PIXELS - 1);
                    1:       a = $urandom_range(0, FB_PIXELS - 1);
                    default: a = $urandom_range(0, 32'hFF_FFFF);
                endcase
                fb.push_back(a[23:16]);
                fb.push_back(a[15:8]);
                fb.push_back(a[7:0]);
                if ($urandom_range(0, 7) == 0) begin
                    fb = fb[0:$urandom_range(1, 3)];
                end else begin
                    n = $urandom_range(0, 10);
                    repeat (n) fb.push_back(8'($urandom_range(0, 255)));
                end
            end else if (sel < 8) begin
                fb.push_back(8'h02);
                fb.push_back(8'($urandom_range(0, 255)));
                n = $urandom_range(0, 10);
                repeat (n) fb.push_back(8'($urandom_range(0, 255)));
            end else begin
                do c = 8'($urandom_range(0, 255)); while (c inside {8'h01, 8'h02, 8'h03});
                fb.push_back(c);
                n = $urandom_range(0, 4);
                repeat (n) fb.push_back(8'($urandom_range(0, 255)));
            end
            model_frame(fb, eb);
            send_frame(fb, 1'($urandom_range(0, 1)));
            check("rand_bad_cmd", 32'(bad_cmd), 32'(eb));
            check("rand_overrun", 32'(overrun), 32'd0);
        end

        // Reset in the middle of a fill aborts it immediately.
        ignore_writes = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        byte_in = 8'h03; byte_valid = 1'b1;
        tick();
        byte_in = 8'h55;
        tick();
        byte_valid = 1'b0;
        repeat (50) tick();
        check("prefill_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midfill_reset");
        ignore_writes = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_reset_busy", 32'(busy), 32'd0);
        fb = '{8'h01, 8'h00, 8'h01, 8'h2C, 8'hAA, 8'hBB};
        model_frame(fb, eb);
        send_frame(fb, 1'b0);

        // Full fill: busy for exactly FB_PIXELS cycles; a byte during it sets overrun.
        fb = '{8'h03, 8'h7E};
        model_frame(fb, eb);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        byte_in = 8'h03; byte_valid = 1'b1;
        tick();
        byte_in = 8'h7E;
        tick();
        byte_valid = 1'b0;
        fill_cycles = 0;
        for (int cyc = 0; cyc < 80000; cyc++) begin
            @(negedge clk);
            byte_valid  = 1'b0;
            frame_start = 1'b0;
            frame_end   = 1'b0;
            if (busy) begin
                fill_cycles++;
                if (fill_cycles == 100) begin
                    byte_in = 8'h99; byte_valid = 1'b1; frame_start = 1'b1;
                end
                if (fill_cycles == 200) frame_end = 1'b1;
            end else if (fill_cycles > 0) begin
                break;
            end
        end
        check("fill_busy_cycles", 32'(fill_cycles), FB_PIXELS);
        check("fill_overrun", 32'(overrun), 32'd1);
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("overrun_cleared", 32'(overrun), 32'd0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;

        repeat (10) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_fb_loader.md
SPI_FB_LOADER -- requirements
Module: spi_fb_loader

Interface
REQ-001 SHALL have parameter FB_PIXELS, default 76800, number of 8-bit framebuffer entries (320x240).
REQ-002 SHALL have parameter FB_AW, default 17, framebuffer address width.
REQ-003 SHALL have ports:
- clk, in, 1: single clock; all logic on posedge clk.
- rst_n, in, 1: asynchronous active-low reset.
- byte_in, in, 8: received SPI byte.
- byte_valid, in, 1: byte_in is valid this cycle; one-cycle pulse per byte.
- frame_start, in, 1: chip-select asserted pulse.
- frame_end, in, 1: chip-select released pulse.
- rgb_addr, out, FB_AW: framebuffer write address.
- rgb_in, out, 8: framebuffer write data (palette index).
- wren_rgb, out, 1: framebuffer write strobe.
- palette_addr, out, 8: palette write index.
- palette_in, out, 24: palette write data {R,G,B}.
- wren_palette, out, 1: palette write strobe.
- busy, out, 1: fill in progress.
- overrun, out, 1: sticky; byte received while busy.
- bad_cmd, out, 1: sticky; unknown command received.

Function
REQ-004 SHALL implement states IDLE, CMD, ADDR2, ADDR1, ADDR0, PIX, PAL_IDX, PAL_R, PAL_G, PAL_B, FILL_VAL, FILL, DISCARD.
REQ-005 SHALL move IDLE->CMD on frame_start; frame_start in any state except FILL SHALL force CMD and abandon any partial transaction.
REQ-006 SHALL, in CMD, decode the first byte: 0x01->ADDR2, 0x02->PAL_IDX, 0x03->FILL_VAL, any other->DISCARD with bad_cmd set.
REQ-007 SHALL capture address bytes big-endian (ADDR2=bits 23:16, ADDR1=15:8, ADDR0=7:0), keep the low FB_AW bits, and reduce a value >= FB_PIXELS to 0.
REQ-008 SHALL, in PIX, issue one write per byte: rgb_addr = current address, rgb_in = byte, wren_rgb high exactly one cycle, the cycle after byte_valid.
REQ-009 SHALL increment the pixel address after each write; FB_PIXELS-1 SHALL wrap to 0.
REQ-010 SHALL take the palette start index in PAL_IDX, then cycle PAL_R->PAL_G->PAL_B->PAL_R per byte.
REQ-011 SHALL, on the PAL_B byte, pulse wren_palette one cycle later with palette_in={R,G,B} and palette_addr=index, then increment the index modulo 256.
REQ-012 SHALL, in FILL_VAL, latch the fill byte and enter FILL with busy high on the next cycle.
REQ-013 SHALL, in FILL, write the fill byte to addresses 0..FB_PIXELS-1 ascending, one per cycle, wren_rgb continuously high.
REQ-014 SHALL leave FILL exactly FB_PIXELS cycles after entry, dropping busy and going to IDLE.
REQ-015 SHALL ignore frame_start, frame_end and bytes in FILL; byte_valid in FILL SHALL set overrun.
REQ-016 SHALL return any non-FILL state to IDLE on frame_end; a partial palette triplet or partial address SHALL be discarded without a write.
REQ-017 SHALL, when frame_end and byte_valid coincide, process the byte first, then go to IDLE.
REQ-018 SHALL ignore byte_valid in IDLE and DISCARD; no strobes.
REQ-019 SHALL clear overrun and bad_cmd on a frame_start accepted outside FILL.
REQ-020 SHALL hold rgb_addr, rgb_in, palette_addr and palette_in stable whenever their strobe is low.
REQ-021 SHALL never assert wren_rgb and wren_palette in the same cycle.

Reset
REQ-022 SHALL, while rst_n is low, force state IDLE and drive every output and internal counter to 0.
REQ-023 SHALL, when rst_n is asserted mid-fill or mid-transaction, abort immediately with no further strobes.
REQ-024 SHALL respond to a frame_start no earlier than the first clk edge after rst_n deasserts.

Verification
REQ-025 SHALL pass pixel write: frame_start, bytes 01 00 01 2C AA BB, frame_end -> wren_rgb pulses with (300,AA) then (301,BB).
REQ-026 SHALL pass pixel wrap: address 0x012BFF (76799), data 11 22 -> writes (76799,11) then (0,22).
REQ-027 SHALL pass palette write: bytes 02 FF 10 20 30 40 50 60 -> writes (255,102030) then (0,405060).
REQ-028 SHALL pass partial triplet: bytes 02 05 10 20 then frame_end -> no wren_palette; the next frame starts clean.
REQ-029 SHALL pass fill: bytes 03 7E -> busy high 76800 cycles, writes 0..76799 =7E; a byte during fill sets overrun; the next frame_start clears it.
REQ-030 SHALL pass bad command and reset: byte 09 sets bad_cmd, later bytes give no strobes; rst_n low mid-fill zeroes all outputs at once.
